nios_ocimem_access_arbiter: RTL and testbench

//  Shares the single-port on-chip debug RAM between two requesters:
//  - JTAG debug sequencer: single-cycle take_action_ocimem_* strobes with jdo payload
//  - CPU debug slave: Avalon-style, waitrequest-based

---
 rtl/nios_ocimem_access_arbiter_if.sv | 23 ++
 rtl/nios_ocimem_access_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_nios_ocimem_access_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_ocimem_access_arbiter_if.sv
// Avalon-style CPU debug-slave bus into the on-chip debug RAM arbiter.
//   master modport : CPU side, drives address/read/write/writedata
//   slave modport  : arbiter side, returns readdata/waitrequest
interface nios_ocimem_access_arbiter_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/nios_ocimem_access_arbiter.sv
// Shares the single-port on-chip debug RAM between the JTAG debug sequencer
// (single-cycle take_action_ocimem_* strobes, latched here) and the CPU debug
// slave (Avalon, waitrequest-based), with round-robin arbitration.
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   take_action_ocimem_a/b   JTAG address-load / write-data strobes, jdo payload
//   take_no_action_ocimem_a  JTAG status poll, clears monitor_error
//   MonDReg, monitor_ready, monitor_error   status back to the TCK logic
//   avs                      CPU debug-slave bus (slave modport)
//   cpu_wprot_err            pulse when a protected CPU write is dropped
//   ram_*                    single-port RAM, read data one cycle after ram_en
//
// Optional feature: define OCIMEM_CPU_WPROT_EN to block CPU writes at word
// addresses >= PROT_BASE (handshake still completes, cpu_wprot_err pulses).
module nios_ocimem_access_arbiter #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hE0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  input  logic [37:0]         jdo,
  output logic [31:0]         MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  nios_ocimem_access_arbiter_if.slave avs,
  output logic                cpu_wprot_err,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StJAcc  = 3'd1;
  localparam logic [2:0] StJDone = 3'd2;
  localparam logic [2:0] StCAcc  = 3'd3;
  localparam logic [2:0] StCDone = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              jtag_pend_q, jtag_pend_d;
  logic              jtag_wr_q, jtag_wr_d;
  logic              last_jtag_q, last_jtag_d;  // last grant went to JTAG
  logic              err_q, err_d;

  logic jtag_busy, accept_a, accept_b, strobe_err, new_pend, cpu_req, prot_hit;
  logic waitrequest;
  logic [31:0] readdata;

  assign jtag_busy  = jtag_pend_q | (state_q == StJAcc) | (state_q == StJDone);
  assign accept_a   = take_action_ocimem_a & ~jtag_busy;
  assign accept_b   = take_action_ocimem_b & ~take_action_ocimem_a & ~jtag_busy;
  assign strobe_err = (take_action_ocimem_a & take_action_ocimem_b) |
                      ((take_action_ocimem_a | take_action_ocimem_b) & jtag_busy);
  assign new_pend   = (accept_a & jdo[34]) | accept_b;
  assign cpu_req    = avs.avs_read | avs.avs_write;

`ifdef OCIMEM_CPU_WPROT_EN
  assign prot_hit = avs.avs_write & (avs.avs_address >= PROT_BASE);
`else
  logic unused_prot_base;
  assign unused_prot_base = ^PROT_BASE;
  assign prot_hit         = 1'b0;
`endif

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

  always_comb begin
    state_d       = state_q;
    mon_a_d       = mon_a_q;
    mon_d_d       = mon_d_q;
    jtag_pend_d   = jtag_pend_q;
    jtag_wr_d     = jtag_wr_q;
    last_jtag_d   = last_jtag_q;
    err_d         = err_q;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    waitrequest   = 1'b1;
    readdata      = '0;
    cpu_wprot_err = 1'b0;

    if (accept_a) begin
      mon_a_d = jdo[ADDR_W+1:2];
      if (jdo[34]) begin
        jtag_pend_d = 1'b1;
        jtag_wr_d   = 1'b0;
      end
    end
    if (accept_b) begin
      mon_d_d     = jdo[34:3];
      jtag_pend_d = 1'b1;
      jtag_wr_d   = 1'b1;
    end

    // A new error outranks a clearing poll in the same cycle.
    if (strobe_err) begin
      err_d = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      err_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        // While a strobe is being latched, wait one cycle so the JTAG request
        // competes against the CPU fairly instead of losing to it.
        if (!new_pend) begin
          if (jtag_pend_q && cpu_req) begin
            state_d = last_jtag_q ? StCAcc : StJAcc;
          end else if (jtag_pend_q) begin
            state_d = StJAcc;
          end else if (cpu_req) begin
            state_d = StCAcc;
          end
        end
      end
      StJAcc: begin
        ram_en    = 1'b1;
        ram_we    = jtag_wr_q;
        ram_addr  = mon_a_q;
        ram_wdata = mon_d_q;
        state_d   = StJDone;
      end
      StJDone: begin
        if (!jtag_wr_q) begin
          mon_d_d = ram_rdata;
        end
        mon_a_d     = mon_a_q + 1'b1;
        jtag_pend_d = 1'b0;
        last_jtag_d = 1'b1;
        state_d     = StIdle;
      end
      StCAcc: begin
        ram_en    = ~prot_hit;
        ram_we    = avs.avs_write & ~prot_hit;
        ram_addr  = avs.avs_address;
        ram_wdata = avs.avs_writedata;
        state_d   = StCDone;
      end
      StCDone: begin
        waitrequest   = 1'b0;
        readdata      = ram_rdata;
        cpu_wprot_err = prot_hit;
        last_jtag_d   = 1'b0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      jtag_pend_q <= 1'b0;
      jtag_wr_q   <= 1'b0;
      last_jtag_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      jtag_pend_q <= jtag_pend_d;
      jtag_wr_q   <= jtag_wr_d;
      last_jtag_q <= last_jtag_d;
      err_q       <= err_d;
    end
  end

  assign MonDReg             = mon_d_q;
  assign monitor_error       = err_q;
  assign monitor_ready       = ~jtag_busy;
  assign avs.avs_waitrequest = waitrequest;
  assign avs.avs_readdata    = readdata;

endmodule

// File: tb/tb_nios_ocimem_access_arbiter.sv
module tb_nios_ocimem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, cpu_wprot_err;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  nios_ocimem_access_arbiter_if #(.ADDR_W(8)) avs_bus ();

  nios_ocimem_access_arbiter #(.ADDR_W(8), .PROT_BASE(8'hE0)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs                     (avs_bus),
    .cpu_wprot_err           (cpu_wprot_err),
    .ram_en                  (ram_en),
    .ram_we                  (ram_we),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural debug RAM, one-cycle read latency, preset contents on reset.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hCAFEF00D;
      ram_rdata  <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[9:2] = addr;
    jdo[34] = rd;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    avs_bus.avs_address = '0;
    avs_bus.avs_read = 1'b0;
    avs_bus.avs_write = 1'b0;
    avs_bus.avs_writedata = '0;
    wait_cycles(3);

    // Reset state
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'h1);
    chk("rst_error", {31'b0, monitor_error}, 32'h0);
    chk("rst_waitreq", {31'b0, avs_bus.avs_waitrequest}, 32'h1);
    chk("rst_readdata", avs_bus.avs_readdata, 32'h0);
    chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
    chk("rst_wprot", {31'b0, cpu_wprot_err}, 32'h0);
    reset_n = 1'b1;
    tick();

    // JTAG read of 0x10: strobe in N, RAM strobe in N+2, result visible in N+4
    strobe_a(8'h10, 1'b1);
    chk("jrd_ready_drop", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("jrd_ram_en", {31'b0, ram_en}, 32'h1);
    chk("jrd_ram_addr", {24'b0, ram_addr}, 32'h10);
    chk("jrd_ram_we", {31'b0, ram_we}, 32'h0);
    tick();
    chk("jrd_busy_done", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("jrd_mondreg", MonDReg, 32'hDEADBEEF);
    chk("jrd_ready", {31'b0, monitor_ready}, 32'h1);

    // JTAG write lands at the post-incremented address 0x11
    strobe_b(32'h11223344);
    chk("jwr_mondreg", MonDReg, 32'h11223344);
    wait_cycles(3);
    chk("jwr_autoinc", mem[8'h11], 32'h11223344);

    // Address-only load of 0xFF, then two writes wrapping to 0x00
    strobe_a(8'hFF, 1'b0);
    chk("aload_ready", {31'b0, monitor_ready}, 32'h1);
    strobe_b(32'h12345678);
    wait_cycles(3);
    strobe_b(32'h12345678);
    wait_cycles(3);
    chk("wrap_ff", mem[8'hFF], 32'h12345678);
    chk("wrap_00", mem[8'h00], 32'h12345678);
    chk("wrap_error", {31'b0, monitor_error}, 32'h0);

    // Uncontended CPU read of 0x10 (leaves last grant = CPU)
    avs_bus.avs_address = 8'h10;
    avs_bus.avs_read = 1'b1;
    tick();
    chk("crd_wait1", {31'b0, avs_bus.avs_waitrequest}, 32'h1);
    chk("crd_ram_addr", {24'b0, ram_addr}, 32'h10);
    tick();
    chk("crd_wait0", {31'b0, avs_bus.avs_waitrequest}, 32'h0);
    chk("crd_data", avs_bus.avs_readdata, 32'hDEADBEEF);
    avs_bus.avs_read = 1'b0;
    tick();

    // CPU read 0x20 and JTAG read 0x10 together: JTAG first, CPU done 6 later
    avs_bus.avs_address = 8'h20;
    avs_bus.avs_read = 1'b1;
    strobe_a(8'h10, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("cont_wait_%0d", k), {31'b0, avs_bus.avs_waitrequest},
          (k == 6) ? 32'h0 : 32'h1);
      if (k == 2) chk("cont_jtag_first", {24'b0, ram_addr}, 32'h10);
      if (k == 6) begin
        chk("cont_cpu_data", avs_bus.avs_readdata, 32'hCAFEF00D);
        avs_bus.avs_read = 1'b0;
      end
      tick();
    end
    chk("cont_mondreg", MonDReg, 32'hDEADBEEF);

    // a and b together: a wins (read of 0x30), b's data is dropped
    jdo = '0;
    jdo[9:2] = 8'h30;
    jdo[34] = 1'b1;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    chk("ab_error", {31'b0, monitor_error}, 32'h1);
    chk("ab_b_dropped", MonDReg, 32'hDEADBEEF);
    // Strobe while busy, with a poll in the same cycle: set wins, strobe dropped
    take_no_action_ocimem_a = 1'b1;
    strobe_b(32'h55555555);
    take_no_action_ocimem_a = 1'b0;
    chk("busy_err_wins", {31'b0, monitor_error}, 32'h1);
    chk("busy_dropped", MonDReg, 32'hDEADBEEF);
    wait_cycles(3);
    chk("ab_read_0x30", MonDReg, 32'h0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    chk("err_cleared", {31'b0, monitor_error}, 32'h0);

    // CPU write to 0xE4: blocked only when protection is built in
    avs_bus.avs_address = 8'hE4;
    avs_bus.avs_writedata = 32'hA5A5A5A5;
    avs_bus.avs_write = 1'b1;
    tick();
`ifdef OCIMEM_CPU_WPROT_EN
    chk("cwp_ram_en", {31'b0, ram_en}, 32'h0);
    chk("cwp_ram_we", {31'b0, ram_we}, 32'h0);
`else
    chk("cwp_ram_en", {31'b0, ram_en}, 32'h1);
    chk("cwp_ram_we", {31'b0, ram_we}, 32'h1);
`endif
    tick();
    chk("cwp_wait0", {31'b0, avs_bus.avs_waitrequest}, 32'h0);
`ifdef OCIMEM_CPU_WPROT_EN
    chk("cwp_pulse", {31'b0, cpu_wprot_err}, 32'h1);
`else
    chk("cwp_pulse", {31'b0, cpu_wprot_err}, 32'h0);
`endif
    avs_bus.avs_write = 1'b0;
    tick();
    chk("cwp_pulse_end", {31'b0, cpu_wprot_err}, 32'h0);
`ifdef OCIMEM_CPU_WPROT_EN
    chk("cwp_mem_e4", mem[8'hE4], 32'h0);
`else
    chk("cwp_mem_e4", mem[8'hE4], 32'hA5A5A5A5);
`endif

    // CPU write just below the protected range always lands
    avs_bus.avs_address = 8'hDF;
    avs_bus.avs_writedata = 32'h0BADF00D;
    avs_bus.avs_write = 1'b1;
    wait_cycles(2);
    chk("cw_df_wait0", {31'b0, avs_bus.avs_waitrequest}, 32'h0);
    chk("cw_df_pulse", {31'b0, cpu_wprot_err}, 32'h0);
    avs_bus.avs_write = 1'b0;
    tick();
    chk("cw_df_mem", mem[8'hDF], 32'h0BADF00D);

    // Reset in the middle of a JTAG access
    strobe_a(8'h10, 1'b1);
    tick();
    chk("mid_ram_en", {31'b0, ram_en}, 32'h1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_ram_en", {31'b0, ram_en}, 32'h0);
    chk("mid_rst_ready", {31'b0, monitor_ready}, 32'h1);
    chk("mid_rst_mondreg", MonDReg, 32'h0);
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
